// File: rtl/button_conditioner_pkg.sv
// Shared constants for the dispenser panel input stage: debounce defaults, input bit positions
// and a small one-hot helper.
package button_conditioner_pkg;

  localparam int unsigned DebCyclesDef = 500000;  // 10 ms at 50 MHz
  localparam int unsigned CntWDef      = 20;

  localparam int unsigned NumBtn = 6;
  localparam int unsigned NumSw  = 3;

  // btn_raw bit order {Start,Back,N,R,G,A}
  localparam int unsigned IdxA     = 0;
  localparam int unsigned IdxG     = 1;
  localparam int unsigned IdxR     = 2;
  localparam int unsigned IdxN     = 3;
  localparam int unsigned IdxBack  = 4;
  localparam int unsigned IdxStart = 5;

  // sw_raw bit order {Mayor,B[1],B[0]}
  localparam int unsigned IdxB0    = 0;
  localparam int unsigned IdxB1    = 1;
  localparam int unsigned IdxMayor = 2;

  // True when two or more bits of the product group are set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One input bit: 2-flop synchroniser followed by a stability counter that only accepts a new
// level after DebCycles consecutive differing samples.
module button_conditioner_debounce_cell #(
  parameter int unsigned DebCycles = 4,
  parameter int unsigned CntW      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic st_o
);

  localparam logic [CntW-1:0] CntLast = CntW'(DebCycles - 1);

  logic            sync1_q, sync2_q;
  logic            st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (sync2_q == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      st_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  assign st_o = st_q;

endmodule

// File: rtl/button_conditioner.sv
// Dispenser panel front end: debounces buttons and switches, converts button presses into
// single-cycle pulses and suppresses simultaneous product selections.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NumBtn-1:0] btn_raw,
  input  logic [NumSw-1:0]  sw_raw,
  output logic             A,
  output logic             G,
  output logic             R,
  output logic             N,
  output logic             Back,
  output logic             Start,
  output logic [1:0]       B,
  output logic             Mayor,
  output logic             multi_err
);

  logic [NumBtn-1:0] btn_st;
  logic [NumSw-1:0]  sw_st;

  for (genvar i = 0; i < NumBtn; i++) begin : g_btn
    button_conditioner_debounce_cell #(
      .DebCycles (DEB_CYCLES),
      .CntW      (CNT_W)
    ) u_cell (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (btn_raw[i]),
      .st_o  (btn_st[i])
    );
  end

  for (genvar i = 0; i < NumSw; i++) begin : g_sw
    button_conditioner_debounce_cell #(
      .DebCycles (DEB_CYCLES),
      .CntW      (CNT_W)
    ) u_cell (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (sw_raw[i]),
      .st_o  (sw_st[i])
    );
  end

  logic [NumBtn-1:0] btn_st_q;
  logic [NumBtn-1:0] rise;
  logic [NumBtn-1:0] pulse_q, pulse_d;
  logic              err_q, err_d;
  logic              multi;

  assign rise  = btn_st & ~btn_st_q;
  assign multi = multi_hot(rise[IdxN:IdxA]);

  always_comb begin
    pulse_d = '0;
    err_d   = multi;
    pulse_d[IdxBack]  = rise[IdxBack];
    pulse_d[IdxStart] = rise[IdxStart];
    // A conflicting product selection is dropped entirely rather than prioritised.
    if (!multi) begin
      pulse_d[IdxN:IdxA] = rise[IdxN:IdxA];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_st_q <= '0;
      pulse_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      btn_st_q <= btn_st;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign A         = pulse_q[IdxA];
  assign G         = pulse_q[IdxG];
  assign R         = pulse_q[IdxR];
  assign N         = pulse_q[IdxN];
  assign Back      = pulse_q[IdxBack];
  assign Start     = pulse_q[IdxStart];
  assign multi_err = err_q;
  assign B         = {sw_st[IdxB1], sw_st[IdxB0]};
  assign Mayor     = sw_st[IdxMayor];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: each press pushes its expected pulse pattern and cycle; a negedge monitor
// compares every cycle's pulse outputs against the queue (zero when nothing is due).
module tb_button_conditioner;

  localparam int unsigned Deb = 4;
  // Input driven just after edge c is first sampled at c+1; pulse is registered at c+1+Deb+2.
  localparam int Lat = Deb + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] btn_raw = '0;
  logic [2:0] sw_raw = '0;
  logic       A, G, R, N, Back, Start, Mayor, multi_err;
  logic [1:0] B;

  button_conditioner #(
    .DEB_CYCLES (Deb),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .A         (A),
    .G         (G),
    .R         (R),
    .N         (N),
    .Back      (Back),
    .Start     (Start),
    .B         (B),
    .Mayor     (Mayor),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [6:0] val;  // {multi_err,Start,Back,N,R,G,A}
  } exp_t;

  exp_t sb_q[$];
  bit   mon_en = 1'b0;

  task automatic push(input logic [6:0] v);
    exp_t e;
    e.cyc = cyc + Lat;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] exp_v;
    if (mon_en) begin
      exp_v = '0;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check_eq("sb_stale", sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        exp_v = sb_q[0].val;
        void'(sb_q.pop_front());
      end
      check_eq("pulses", {multi_err, Start, Back, N, R, G, A}, exp_v);
    end
  end

  task automatic release_all();
    btn_raw = '0;
    step(12);
  endtask

  initial begin
    step(3);
    check_eq("reset_outs", {multi_err, Start, Back, N, R, G, A, B, Mayor}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Clean press of A, long hold, release without pulse
    btn_raw[0] = 1'b1;
    push(7'b0000001);
    step(20);
    release_all();

    // Bouncing Start: only the final steady high counts
    btn_raw[5] = 1'b1; step(1);
    btn_raw[5] = 1'b0; step(1);
    btn_raw[5] = 1'b1; step(1);
    btn_raw[5] = 1'b0; step(1);
    btn_raw[5] = 1'b1;
    push(7'b0100000);
    step(15);
    release_all();

    // G and N together: product group suppressed, multi_err pulses
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    push(7'b1000000);
    step(15);
    release_all();

    // A with Back: independent groups, both pulse
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    push(7'b0010001);
    step(15);
    release_all();

    // Switch levels: last cycle before acceptance, then accepted
    sw_raw = 3'b110;
    step(5);
    check_eq("sw_before_B", B, 2'b00);
    check_eq("sw_before_mayor", Mayor, 1'b0);
    step(1);
    check_eq("sw_after_B", B, 2'b10);
    check_eq("sw_after_mayor", Mayor, 1'b1);
    sw_raw[0] = 1'b1;
    step(2);
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_eq("sw_glitch_B", B, 2'b10);
    end
    sw_raw = 3'b000;
    step(10);
    check_eq("sw_release", {B, Mayor}, 3'b000);

    // Reset mid-debounce: held R pulses after full latency from release
    btn_raw[2] = 1'b1;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check_eq("in_reset_outs", {multi_err, Start, Back, N, R, G, A, B, Mayor}, 0);
    end
    reset = 1'b0;
    push(7'b0000100);
    step(15);
    release_all();

    // Long hold of Back gives a single pulse
    btn_raw[4] = 1'b1;
    push(7'b0010000);
    step(100);
    release_all();

    mon_en = 1'b0;
    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
